// File: rtl/ntt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_seq_pkg
// Purpose  : Shared definitions for the 512-point NTT operation sequencer:
//            sequencer state encoding, conf codes driven to the address/control
//            FSM, done_flag bit positions and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ntt_seq_pkg;

  // Sequencer states; the encoding is visible on the phase debug port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PASS_A  = 3'd1,
    ST_DRAIN_A = 3'd2,
    ST_PASS_B  = 3'd3,
    ST_DRAIN_B = 3'd4,
    ST_FINISH  = 3'd5
  } seq_state_t;

  // conf codes understood by the address/control FSM
  localparam logic [3:0] CONF_IDLE         = 4'b0000;
  localparam logic [3:0] CONF_R2_NTT       = 4'b0001;
  localparam logic [3:0] CONF_R4_NTT       = 4'b0010;
  localparam logic [3:0] CONF_DONE_R2_NTT  = 4'b0011;
  localparam logic [3:0] CONF_DONE_R4_NTT  = 4'b0100;
  localparam logic [3:0] CONF_R4_INTT      = 4'b0101;
  localparam logic [3:0] CONF_R2_INTT      = 4'b0110;
  localparam logic [3:0] CONF_DONE_R2_INTT = 4'b0111;
  localparam logic [3:0] CONF_DONE_R4_INTT = 4'b1000;

  // done_flag bit positions
  localparam int R2_DONE_BIT = 0;
  localparam int R4_DONE_BIT = 1;

  // Forward NTT runs radix-2 then radix-4; INTT runs radix-4 then radix-2.
  function automatic logic [3:0] conf_for(input seq_state_t st, input logic inv);
    logic [3:0] c;
    c = CONF_IDLE;
    case (st)
      ST_PASS_A:  c = inv ? CONF_R4_INTT      : CONF_R2_NTT;
      ST_DRAIN_A: c = inv ? CONF_DONE_R4_INTT : CONF_DONE_R2_NTT;
      ST_PASS_B:  c = inv ? CONF_R2_INTT      : CONF_R4_NTT;
      ST_DRAIN_B: c = inv ? CONF_DONE_R2_INTT : CONF_DONE_R4_NTT;
      default:    c = CONF_IDLE;
    endcase
    return c;
  endfunction

  // Selects the done bit belonging to the radix of the current pass.
  function automatic logic pass_done_bit(input seq_state_t st, input logic inv,
                                         input logic [1:0] flags);
    logic radix4;
    radix4 = (st == ST_PASS_B) ? ~inv : inv;
    return radix4 ? flags[R4_DONE_BIT] : flags[R2_DONE_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_seq_timer
// Purpose  : Loadable down-counter with terminal-count flag. Shared by the
//            drain hold and the per-pass watchdog of the NTT sequencer.
// Ports    : clk, rst (async, active-high)
//            load     - load load_val this edge (has priority over counting)
//            load_val - value to load
//            count    - current count (decrements to zero and stops there)
//            tc       - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module ntt_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_op_sequencer
// Purpose  : Operation sequencer for the mixed radix-2/radix-4 512-point NTT
//            core. Accepts one NTT/INTT command, steps the address FSM through
//            two passes via the conf code, holds each DONE code for the wen
//            pipeline drain, and reports completion or error to the host.
// Ports    : clk, rst (async, active-high)
//            cmd_valid/cmd_ready/cmd_inv - command handshake, mode (1 = INTT)
//            abort      - abort request (honoured in passes and first drain)
//            done_flag  - pass-complete bits from address FSM (bit2 reserved)
//            conf       - conf code to address FSM
//            busy, op_done, op_err, phase - status / debug
//            cycles_last - cycles of last operation (PERF_CNT_EN only)
// Options  : PERF_CNT_EN - adds the operation cycle counter and cycles_last
// Revision : 1.0 - initial release
// ============================================================================
module ntt_op_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES = 14,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_inv,
  input  logic             abort,
  input  logic [2:0]       done_flag,
  output logic [3:0]       conf,
  output logic             busy,
  output logic             op_done,
  output logic             op_err,
  output logic [2:0]       phase
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycles_last
`endif
);

  // Timer loads are "length - 1" so terminal count lands on the last cycle.
  localparam logic [CNT_W-1:0] C_TO_LOAD    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  // Pass counter n = TIMEOUT-1-count; done is honoured once n >= 2.
  localparam logic [CNT_W-1:0] C_MASK_LIMIT = CNT_W'(TIMEOUT - 3);

  seq_state_t       r_state, w_state_nxt;
  logic             r_inv, w_inv_nxt;
  logic             r_err, w_err_nxt;
  logic             w_accept;
  logic             w_err_exit;
  logic             w_pass_done;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic [CNT_W-1:0] w_tmr_count;
  logic             w_tmr_tc;
  logic             w_unused_rsvd;

  assign w_unused_rsvd = done_flag[2];

  ntt_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .count    (w_tmr_count),
    .tc       (w_tmr_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_inv_nxt   = r_inv;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;
    w_err_exit  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = C_TO_LOAD;
    w_pass_done = pass_done_bit(r_state, r_inv, done_flag[1:0]) &&
                  (w_tmr_count <= C_MASK_LIMIT);

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_inv_nxt   = cmd_inv;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_PASS_A;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_TO_LOAD;
        end
      end

      ST_PASS_A, ST_PASS_B: begin
        // Abort beats a simultaneous done; a timeout only fires without done.
        if (abort || w_pass_done || w_tmr_tc) begin
          if (abort || !w_pass_done) begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = (r_state == ST_PASS_A) ? ST_DRAIN_A : ST_DRAIN_B;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_DRAIN_LOAD;
        end
      end

      ST_DRAIN_A: begin
        // Abort here still lets the drain run to completion.
        if (abort) begin
          w_err_nxt = 1'b1;
        end
        if (w_tmr_tc) begin
          if (r_err || abort) begin
            w_state_nxt = ST_IDLE;
            w_err_exit  = 1'b1;
          end else begin
            w_state_nxt = ST_PASS_B;
            w_tmr_load  = 1'b1;
            w_tmr_val   = C_TO_LOAD;
          end
        end
      end

      ST_DRAIN_B: begin
        if (w_tmr_tc) begin
          if (r_err) begin
            w_state_nxt = ST_IDLE;
            w_err_exit  = 1'b1;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_inv     <= 1'b0;
      r_err     <= 1'b0;
      conf      <= CONF_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      op_done   <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_inv     <= w_inv_nxt;
      r_err     <= w_err_nxt;
      conf      <= conf_for(w_state_nxt, w_inv_nxt);
      cmd_ready <= (w_state_nxt == ST_IDLE);
      busy      <= (w_state_nxt != ST_IDLE);
      op_done   <= (w_state_nxt == ST_FINISH);
      op_err    <= w_err_exit;
    end
  end

  assign phase = r_state;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_perf;
  logic [CNT_W-1:0] w_perf_inc;

  // Saturating increment; includes the cycle currently being counted.
  assign w_perf_inc = (r_perf == '1) ? r_perf : r_perf + C_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf      <= '0;
      cycles_last <= '0;
    end else begin
      if (w_accept) begin
        r_perf <= C_ONE;  // the accept cycle itself
      end else if (r_state != ST_IDLE) begin
        r_perf <= w_perf_inc;
      end
      if ((r_state == ST_FINISH) || w_err_exit) begin
        cycles_last <= w_perf_inc;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_op_sequencer
// Purpose  : Directed self-checking bench for ntt_op_sequencer. A small model
//            of the address FSM registers conf (one-cycle conf_state lag) and
//            raises the pass done bit when it has seen the pass code for 128
//            (radix-2) or 512 (radix-4) cycles, so a radix-2 pass lasts 129
//            sequencer cycles and a radix-4 pass 513.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_op_sequencer;

  localparam int CNT_W = 16;
  localparam int TO    = 1024;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_inv;
  logic             abort;
  logic [2:0]       done_flag;
  logic [3:0]       conf;
  logic             busy;
  logic             op_done;
  logic             op_err;
  logic [2:0]       phase;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycles_last;
`endif

  ntt_op_sequencer #(.DRAIN_CYCLES(14), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_inv     (cmd_inv),
    .abort       (abort),
    .done_flag   (done_flag),
    .conf        (conf),
    .busy        (busy),
    .op_done     (op_done),
    .op_err      (op_err),
    .phase       (phase)
`ifdef PERF_CNT_EN
    ,
    .cycles_last (cycles_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- address FSM model ----------------
  logic [3:0] conf_q;
  int         mcnt;
  logic       model_en;
  logic [2:0] done_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_q <= 4'd0;
      mcnt   <= 0;
    end else begin
      conf_q <= conf;
      mcnt   <= (conf_q != conf) ? 0 : mcnt + 1;
    end
  end

  assign done_flag = done_force |
    {1'b0,
     model_en && (conf_q == 4'b0010 || conf_q == 4'b0101) && (mcnt == 511),
     model_en && (conf_q == 4'b0001 || conf_q == 4'b0110) && (mcnt == 127)};

  // ---------------- bookkeeping ----------------
  int total;
  int bad;

  int seg_code[8];
  int seg_len[8];
  int nseg;
  int busy_cyc;
  int done_cnt;
  int err_cnt;
  int rdy_busy;

  task automatic start_op(input logic inv);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_inv   = inv;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Records the conf code as run-length segments while busy, optionally
  // raising abort for the single cycle with index abort_cycle (0 = first
  // busy cycle). Returns at the negedge of the first non-busy cycle.
  task automatic capture(input int abort_cycle);
    int k;
    k = 0; nseg = 0; busy_cyc = 0; done_cnt = 0; err_cnt = 0; rdy_busy = 0;
    while (busy === 1'b1 && k < 6000) begin
      if (nseg > 0 && seg_code[nseg-1] == int'(conf)) begin
        seg_len[nseg-1]++;
      end else if (nseg < 8) begin
        seg_code[nseg] = int'(conf);
        seg_len[nseg]  = 1;
        nseg++;
      end
      busy_cyc++;
      if (op_done === 1'b1) done_cnt++;
      if (op_err === 1'b1) err_cnt++;
      if (cmd_ready === 1'b1) rdy_busy++;
      abort = (k == abort_cycle);
      @(negedge clk);
      k++;
    end
    abort = 1'b0;
    total++;
    if (k >= 6000) begin
      bad++;
      $display("FAIL capture_bound: busy still %0b after %0d cycles, want idle", busy, k);
    end
    if (op_done === 1'b1) done_cnt++;
    if (op_err === 1'b1) err_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    total++;
    if (conf !== 4'b0000 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        op_done !== 1'b0 || op_err !== 1'b0 || phase !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: conf=%b rdy=%b busy=%b done=%b err=%b phase=%0d, want 0000 1 0 0 0 0",
               conf, cmd_ready, busy, op_done, op_err, phase);
    end
`ifdef PERF_CNT_EN
    total++;
    if (cycles_last !== 16'd0) begin
      bad++;
      $display("FAIL reset_cycles_last: got %0d want 0", cycles_last);
    end
`endif
    // stray done bits in IDLE must not start anything
    done_force = 3'b111;
    repeat (3) @(negedge clk);
    done_force = 3'b000;
    total++;
    if (busy !== 1'b0 || conf !== 4'b0000 || phase !== 3'd0) begin
      bad++;
      $display("FAIL idle_stray_done: busy=%b conf=%b phase=%0d, want 0 0000 0", busy, conf, phase);
    end
  endtask

  task automatic test_ntt;
    int ec[5];
    int el[5];
    ec = '{1, 3, 2, 4, 0};
    el = '{129, 14, 513, 14, 1};
    start_op(1'b0);
    capture(-1);
    total++;
    if (nseg !== 5) begin bad++; $display("FAIL ntt_nseg: got %0d want 5", nseg); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (seg_code[i] !== ec[i] || seg_len[i] !== el[i]) begin
        bad++;
        $display("FAIL ntt_seg%0d: got conf=%0d x%0d want conf=%0d x%0d", i, seg_code[i], seg_len[i], ec[i], el[i]);
      end
    end
    total++;
    if (busy_cyc !== 671) begin bad++; $display("FAIL ntt_busy_cycles: got %0d want 671", busy_cyc); end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL ntt_pulses: op_done=%0d op_err=%0d want 1 0", done_cnt, err_cnt);
    end
    total++;
    if (rdy_busy !== 0) begin bad++; $display("FAIL ntt_ready_while_busy: got %0d cycles want 0", rdy_busy); end
`ifdef PERF_CNT_EN
    total++;
    if (cycles_last !== 16'd672) begin bad++; $display("FAIL ntt_cycles_last: got %0d want 672", cycles_last); end
`endif
  endtask

  task automatic test_intt;
    int ec[5];
    int el[5];
    ec = '{5, 8, 6, 7, 0};
    el = '{513, 14, 129, 14, 1};
    start_op(1'b1);
    capture(-1);
    total++;
    if (nseg !== 5) begin bad++; $display("FAIL intt_nseg: got %0d want 5", nseg); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (seg_code[i] !== ec[i] || seg_len[i] !== el[i]) begin
        bad++;
        $display("FAIL intt_seg%0d: got conf=%0d x%0d want conf=%0d x%0d", i, seg_code[i], seg_len[i], ec[i], el[i]);
      end
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL intt_pulses: op_done=%0d op_err=%0d want 1 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout;
    // model silent; reserved bit2 held high must not count as done
    model_en   = 1'b0;
    done_force = 3'b100;
    start_op(1'b0);
    capture(-1);
    model_en   = 1'b1;
    done_force = 3'b000;
    total++;
    if (nseg !== 2 || seg_code[0] !== 1 || seg_len[0] !== TO ||
        seg_code[1] !== 3 || seg_len[1] !== 14) begin
      bad++;
      $display("FAIL timeout_segs: nseg=%0d %0dx%0d %0dx%0d want 2 1x%0d 3x14",
               nseg, seg_code[0], seg_len[0], seg_code[1], seg_len[1], TO);
    end
    total++;
    if (err_cnt !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL timeout_pulses: op_err=%0d op_done=%0d want 1 0", err_cnt, done_cnt);
    end
    total++;
    if (phase !== 3'd0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL timeout_idle: phase=%0d rdy=%b want 0 1", phase, cmd_ready);
    end
  endtask

  task automatic test_abort;
    // abort at PASS_B cycle 50 (sequencer cycle 143+50)
    start_op(1'b0);
    capture(193);
    total++;
    if (nseg !== 4 || seg_code[2] !== 2 || seg_len[2] !== 51 ||
        seg_code[3] !== 4 || seg_len[3] !== 14 || seg_len[0] !== 129) begin
      bad++;
      $display("FAIL abort_passb_segs: nseg=%0d A=%0d B=%0dx%0d D=%0dx%0d want 4 129 2x51 4x14",
               nseg, seg_len[0], seg_code[2], seg_len[2], seg_code[3], seg_len[3]);
    end
    total++;
    if (err_cnt !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_passb_pulses: op_err=%0d op_done=%0d want 1 0", err_cnt, done_cnt);
    end
    // abort in the same cycle the radix-2 done is seen: abort wins
    start_op(1'b0);
    capture(128);
    total++;
    if (nseg !== 2 || seg_len[0] !== 129 || seg_code[1] !== 3 || seg_len[1] !== 14 ||
        err_cnt !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_with_done: nseg=%0d A=%0d D=%0dx%0d err=%0d done=%0d want 2 129 3x14 1 0",
               nseg, seg_len[0], seg_code[1], seg_len[1], err_cnt, done_cnt);
    end
    // abort mid DRAIN_A: drain completes, then IDLE with error
    start_op(1'b0);
    capture(135);
    total++;
    if (nseg !== 2 || seg_code[1] !== 3 || seg_len[1] !== 14 || err_cnt !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_draina: nseg=%0d D=%0dx%0d err=%0d done=%0d want 2 3x14 1 0",
               nseg, seg_code[1], seg_len[1], err_cnt, done_cnt);
    end
    // abort during FINISH is ignored
    start_op(1'b0);
    capture(670);
    total++;
    if (nseg !== 5 || done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL abort_finish: nseg=%0d done=%0d err=%0d want 5 1 0", nseg, done_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_inv   = 1'b0;
    @(negedge clk);
    cmd_inv   = 1'b1;  // must not leak into the running operation
    capture(-1);
    total++;
    if (nseg !== 5 || seg_code[0] !== 1 || seg_code[2] !== 2 || done_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_first: nseg=%0d A=%0d B=%0d done=%0d want 5 1 2 1", nseg, seg_code[0], seg_code[2], done_cnt);
    end
    total++;
    if (rdy_busy !== 0) begin bad++; $display("FAIL b2b_ready_while_busy: got %0d want 0", rdy_busy); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || conf !== 4'b0101) begin
      bad++;
      $display("FAIL b2b_second_accept: busy=%b conf=%b want 1 0101", busy, conf);
    end
    capture(-1);
    total++;
    if (nseg !== 5 || seg_code[0] !== 5 || seg_len[0] !== 513 || done_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_second: nseg=%0d A=%0dx%0d done=%0d want 5 5x513 1", nseg, seg_code[0], seg_len[0], done_cnt);
    end
    cmd_inv = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int k;
    start_op(1'b0);
    k = 0;
    while (phase !== 3'd3 && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (phase !== 3'd3) begin bad++; $display("FAIL rst_reach_passb: phase=%0d want 3", phase); end
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (conf !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1 || phase !== 3'd0) begin
      bad++;
      $display("FAIL rst_async: conf=%b busy=%b rdy=%b phase=%0d want 0000 0 1 0", conf, busy, cmd_ready, phase);
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(1'b0);
    capture(-1);
    total++;
    if (nseg !== 5 || seg_len[0] !== 129 || seg_len[2] !== 513 || done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL rst_rerun: nseg=%0d A=%0d B=%0d done=%0d err=%0d want 5 129 513 1 0",
               nseg, seg_len[0], seg_len[2], done_cnt, err_cnt);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_inv    = 1'b0;
    abort      = 1'b0;
    model_en   = 1'b1;
    done_force = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_ntt();
    test_intt();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
